regfile_wb_ctrl: RTL and testbench

REGFILE_WB_CTRL -- requirements
Module: regfile_wb_ctrl

---
 rtl/regfile_wb_ctrl.sv | 118 +++++++++++
 tb/tb_regfile_wb_ctrl.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_ctrl.sv
// Writeback arbiter and clear sweep for a 2R1W register file.
// Define REGFILE_WB_BYPASS_EN to compile in the write-in-flight bypass.
module regfile_wb_ctrl #(
    parameter int WIDTH      = 32,
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  a_valid,
    input  logic [DEPTH_LOG2-1:0] a_addr,
    input  logic [WIDTH-1:0]      a_data,
    output logic                  a_ready,
    input  logic                  b_valid,
    input  logic [DEPTH_LOG2-1:0] b_addr,
    input  logic [WIDTH-1:0]      b_data,
    output logic                  b_ready,
    output logic                  rf_write,
    output logic [DEPTH_LOG2-1:0] rf_write_addr,
    output logic [WIDTH-1:0]      rf_write_data,
    output logic                  init_busy,
    input  logic [DEPTH_LOG2-1:0] rs1_addr,
    input  logic [DEPTH_LOG2-1:0] rs2_addr,
    output logic                  rs1_byp_hit,
    output logic [WIDTH-1:0]      rs1_byp_data,
    output logic                  rs2_byp_hit,
    output logic [WIDTH-1:0]      rs2_byp_data
);

    typedef enum logic {INIT, RUN} state_t;

    localparam logic [DEPTH_LOG2-1:0] LAST = '1;

    state_t                state, state_nxt;
    logic [DEPTH_LOG2-1:0] cnt;
    logic                  rr_b;
    logic                  a_xfer, b_xfer;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= INIT;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            INIT:    if (cnt == LAST) state_nxt = RUN;
            RUN:     state_nxt = RUN;
            default: state_nxt = INIT;
        endcase
    end

    // rr_b=0 favours A on contention, rr_b=1 favours B
    always_comb begin
        init_busy = (state == INIT);
        a_ready   = 1'b0;
        b_ready   = 1'b0;
        if (state == RUN) begin
            a_ready = a_valid && (!b_valid || !rr_b);
            b_ready = b_valid && (!a_valid || rr_b);
        end
    end

    assign a_xfer = a_valid && a_ready;
    assign b_xfer = b_valid && b_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt           <= '0;
            rr_b          <= 1'b0;
            rf_write      <= 1'b0;
            rf_write_addr <= '0;
            rf_write_data <= '0;
        end else if (state == INIT) begin
            cnt           <= cnt + 1'b1;
            rf_write      <= 1'b1;
            rf_write_addr <= cnt;
            rf_write_data <= '0;
        end else begin
            rf_write <= 1'b0;
            // address 0 is hardwired zero: accept but drop the write
            if (a_xfer) begin
                rr_b <= 1'b1;
                if (a_addr != '0) begin
                    rf_write      <= 1'b1;
                    rf_write_addr <= a_addr;
                    rf_write_data <= a_data;
                end
            end else if (b_xfer) begin
                rr_b <= 1'b0;
                if (b_addr != '0) begin
                    rf_write      <= 1'b1;
                    rf_write_addr <= b_addr;
                    rf_write_data <= b_data;
                end
            end
        end
    end

`ifdef REGFILE_WB_BYPASS_EN
    logic byp_ok;
    assign byp_ok = (state == RUN) && rf_write;

    always_comb begin
        rs1_byp_hit  = byp_ok && (rf_write_addr == rs1_addr)
                       && (rs1_addr != '0);
        rs2_byp_hit  = byp_ok && (rf_write_addr == rs2_addr)
                       && (rs2_addr != '0);
        rs1_byp_data = rs1_byp_hit ? rf_write_data : '0;
        rs2_byp_data = rs2_byp_hit ? rf_write_data : '0;
    end
`else
    assign rs1_byp_hit  = 1'b0;
    assign rs2_byp_hit  = 1'b0;
    assign rs1_byp_data = '0;
    assign rs2_byp_data = '0;
`endif

endmodule

// File: tb/tb_regfile_wb_ctrl.sv
// Directed bench for regfile_wb_ctrl with a writeback scoreboard.
// Bypass expectations follow REGFILE_WB_BYPASS_EN.
module tb_regfile_wb_ctrl;

    localparam int W  = 32;
    localparam int AW = 4;
    localparam int D  = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          a_valid = 1'b0, b_valid = 1'b0;
    logic [AW-1:0] a_addr = '0, b_addr = '0;
    logic [W-1:0]  a_data = '0, b_data = '0;
    logic          a_ready, b_ready;
    logic          rf_write;
    logic [AW-1:0] rf_write_addr;
    logic [W-1:0]  rf_write_data;
    logic          init_busy;
    logic [AW-1:0] rs1_addr = '0, rs2_addr = '0;
    logic          rs1_byp_hit, rs2_byp_hit;
    logic [W-1:0]  rs1_byp_data, rs2_byp_data;

    regfile_wb_ctrl #(.WIDTH(W), .DEPTH_LOG2(AW)) dut (
        .clk(clk), .rst(rst),
        .a_valid(a_valid), .a_addr(a_addr), .a_data(a_data),
        .a_ready(a_ready),
        .b_valid(b_valid), .b_addr(b_addr), .b_data(b_data),
        .b_ready(b_ready),
        .rf_write(rf_write), .rf_write_addr(rf_write_addr),
        .rf_write_data(rf_write_data), .init_busy(init_busy),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
        .rs1_byp_hit(rs1_byp_hit), .rs1_byp_data(rs1_byp_data),
        .rs2_byp_hit(rs2_byp_hit), .rs2_byp_data(rs2_byp_data)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic          w;
        logic [AW-1:0] addr;
        logic [W-1:0]  data;
    } exp_t;

    exp_t          sb[$];
    int            n_chk = 0;
    int            n_fail = 0;
    logic          rr_m = 1'b0;
    logic [AW-1:0] la = '0;
    logic [W-1:0]  ld = '0;
`ifdef REGFILE_WB_BYPASS_EN
    localparam logic BYP = 1'b1;
`else
    localparam logic BYP = 1'b0;
`endif

    task automatic chk(input string tag, input logic [W-1:0] obs,
                       input logic [W-1:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic pop_chk(input string tag);
        exp_t e;
        e = sb.pop_front();
        chk({tag, ".rf_write"}, W'(rf_write), W'(e.w));
        chk({tag, ".addr"}, W'(rf_write_addr), W'(e.addr));
        chk({tag, ".data"}, rf_write_data, e.data);
    endtask

    // one RUN cycle: drive, check readies, predict write, clock, compare
    task automatic cyc(input string tag,
                       input logic av, input logic [AW-1:0] aa,
                       input logic [W-1:0] ad,
                       input logic bv, input logic [AW-1:0] ba,
                       input logic [W-1:0] bd);
        logic ga, gb;
        exp_t e;
        a_valid = av; a_addr = aa; a_data = ad;
        b_valid = bv; b_addr = ba; b_data = bd;
        #1;
        ga = av && (!bv || !rr_m);
        gb = bv && (!av || rr_m);
        chk({tag, ".a_ready"}, W'(a_ready), W'(ga));
        chk({tag, ".b_ready"}, W'(b_ready), W'(gb));
        if (ga || gb) rr_m = ga;
        e.w = 1'b0;
        if (ga && aa != '0) begin
            e.w = 1'b1; la = aa; ld = ad;
        end else if (gb && ba != '0) begin
            e.w = 1'b1; la = ba; ld = bd;
        end
        e.addr = la;
        e.data = ld;
        sb.push_back(e);
        @(posedge clk); #1;
        pop_chk(tag);
    endtask

    // clear sweep with both sources requesting; n edges
    task automatic sweep(input string tag, input int n);
        exp_t e;
        a_valid = 1'b1; a_addr = 4'd2; a_data = 32'h1111;
        b_valid = 1'b1; b_addr = 4'd3; b_data = 32'h2222;
        for (int i = 0; i < n; i++) begin
            #1;
            chk({tag, ".busy"}, W'(init_busy), W'(1'b1));
            chk({tag, ".a_ready"}, W'(a_ready), W'(1'b0));
            chk({tag, ".b_ready"}, W'(b_ready), W'(1'b0));
            e.w = 1'b1; e.addr = AW'(i); e.data = '0;
            sb.push_back(e);
            @(posedge clk); #1;
            pop_chk($sformatf("%s[%0d]", tag, i));
            if (i > 0 && i < D - 1) begin
                rs1_addr = AW'(i);
                #1;
                chk({tag, ".byp_init"}, W'(rs1_byp_hit), W'(1'b0));
            end
        end
        if (n == D)
            chk({tag, ".busy_end"}, W'(init_busy), W'(1'b0));
        la = AW'(D - 1); ld = '0; rr_m = 1'b0;
        a_valid = 1'b0; b_valid = 1'b0;
    endtask

    initial begin
        #2;
        chk("rst.rf_write", W'(rf_write), W'(1'b0));
        chk("rst.busy", W'(init_busy), W'(1'b1));
        chk("rst.a_ready", W'(a_ready), W'(1'b0));
        chk("rst.hit", W'(rs1_byp_hit), W'(1'b0));
        @(posedge clk); #1;
        rst = 1'b0;
        sweep("init", D);

        cyc("a_only", 1, 4'd5, 32'hDEADBEEF, 0, 4'd0, 32'h0);
        cyc("b_zero", 0, 4'd0, 32'h0, 1, 4'd0, 32'h1234);
        cyc("idle", 0, 4'd0, 32'h0, 0, 4'd0, 32'h0);
        for (int k = 0; k < 4; k++)
            cyc($sformatf("cont%0d", k),
                1, 4'd3, 32'h3333, 1, 4'd7, 32'h7777);

        cyc("byp_wr", 1, 4'd9, 32'h55AA, 0, 4'd0, 32'h0);
        rs1_addr = 4'd9; rs2_addr = 4'd4;
        #1;
        chk("byp.rs1_hit", W'(rs1_byp_hit), W'(BYP));
        chk("byp.rs1_data", rs1_byp_data, BYP ? 32'h55AA : 32'h0);
        chk("byp.rs2_hit", W'(rs2_byp_hit), W'(1'b0));
        chk("byp.rs2_data", rs2_byp_data, 32'h0);
        cyc("byp_idle", 0, 4'd0, 32'h0, 0, 4'd0, 32'h0);
        chk("byp.none", W'(rs1_byp_hit), W'(1'b0));

        cyc("pre_rst", 0, 4'd0, 32'h0, 1, 4'd6, 32'h6666);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        sweep("part", 6);
        rs1_addr = 4'd5;
        a_valid = 1'b1; b_valid = 1'b1;
        rst = 1'b1;
        #1;
        chk("mid.rf_write", W'(rf_write), W'(1'b0));
        chk("mid.addr", W'(rf_write_addr), W'(0));
        chk("mid.busy", W'(init_busy), W'(1'b1));
        chk("mid.a_ready", W'(a_ready), W'(1'b0));
        chk("mid.b_ready", W'(b_ready), W'(1'b0));
        chk("mid.hit", W'(rs1_byp_hit), W'(1'b0));
        @(posedge clk); #1;
        rst = 1'b0;
        sweep("resweep", D);
        cyc("rr_after_rst", 1, 4'd1, 32'hA1, 1, 4'd2, 32'hB2);
        cyc("rr_next", 1, 4'd1, 32'hA1, 1, 4'd2, 32'hB2);

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule
